// File: rtl/freq_pkg.sv
// Shared definitions for the frequency-counter reporting path.
// Contents:
//   COUNT_W, BCD_DIGITS, BCD_W  - count word and BCD register sizing
//   ASCII_ZERO/CR/LF            - characters placed on the serial line
//   rpt_state_t                 - report FSM state encoding
//   bcd_step()                  - one double-dabble iteration (add-3, then shift in a bit)
//   bcd_digit()                 - select one BCD digit by index
package freq_pkg;

    localparam int COUNT_W    = 40;
    localparam int BCD_DIGITS = 13;
    localparam int BCD_W      = BCD_DIGITS * 4;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONVERT,
        ST_SKIPZ,
        ST_SEND_DIG,
        ST_SEND_CR,
        ST_SEND_LF
    } rpt_state_t;

    // Every nibble >= 5 gets +3 (4-bit, no inter-nibble carry), then the whole
    // register shifts left by one with bit_in entering at bit 0. Built bit by
    // bit so the adjusted top bit, which is shifted out, never needs a home.
    function automatic logic [BCD_W-1:0] bcd_step(input logic [BCD_W-1:0] bcd,
                                                   input logic             bit_in);
        logic [BCD_W-1:0] r;
        logic [3:0]       nib;
        r    = '0;
        r[0] = bit_in;
        for (int i = 0; i < BCD_W - 1; i++) begin
            nib = bcd[(i / 4) * 4 +: 4];
            if (nib >= 4'd5) nib = nib + 4'd3;
            r[i + 1] = nib[i % 4];
        end
        return r;
    endfunction

    function automatic logic [3:0] bcd_digit(input logic [BCD_W-1:0] bcd,
                                             input logic [3:0]       idx);
        logic [3:0] d;
        d = '0;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (idx == 4'(i)) d = bcd[i * 4 +: 4];
        end
        return d;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte transmitter, LSB first.
// Ports:
//   clk, rst   - system clock, synchronous active-high reset
//   start      - one-cycle request, taken only while busy is low
//   data[7:0]  - byte to send, captured on the accepted start
//   tx         - serial line, idles high
//   busy       - high from the accepted start until the stop bit completes
//   done       - one-cycle pulse the cycle after the stop bit's last clock
// Parameter DIV is the bit period in clock cycles.
module uart_tx_byte #(
    parameter int DIV = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int            CW     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

    logic [CW-1:0] baud_cnt;
    logic [3:0]    bit_idx;    // 0 = start bit, 1..8 = data, 9 = stop
    logic [8:0]    shreg;      // remaining data bits plus the stop bit

    always_ff @(posedge clk) begin
        if (rst) begin
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '1;
        end else begin
            done <= 1'b0;
            if (!busy) begin
                if (start) begin
                    busy     <= 1'b1;
                    tx       <= 1'b0;
                    shreg    <= {1'b1, data};
                    baud_cnt <= RELOAD;
                    bit_idx  <= '0;
                end
            end else if (baud_cnt != '0) begin
                baud_cnt <= baud_cnt - 1'b1;
            end else if (bit_idx == 4'd9) begin
                busy <= 1'b0;
                done <= 1'b1;
                tx   <= 1'b1;
            end else begin
                tx       <= shreg[0];
                shreg    <= {1'b1, shreg[8:1]};
                bit_idx  <= bit_idx + 4'd1;
                baud_cnt <= RELOAD;
            end
        end
    end

endmodule

// File: rtl/freq_report_uart.sv
// Converts each completed gate count to unsigned decimal and sends it as
// ASCII digits followed by CR LF on an 8N1 UART line.
// Ports:
//   clk, rst     - system clock, synchronous active-high reset
//   count_in     - gate count, stable while count_valid is high
//   count_valid  - one-cycle pulse, new count available
//   uart_tx      - serial line, idles high
//   busy         - high from acceptance of a count until the LF stop bit ends
//   overrun      - one-cycle pulse when a count arrives outside IDLE (count dropped)
//
// state        | meaning
// ST_IDLE      | waiting for count_valid
// ST_CONVERT   | double-dabble, one shift per cycle for COUNT_W cycles
// ST_SKIPZ     | dropping leading zero digits, always keeping digit 0
// ST_SEND_DIG  | sending digits, most significant first
// ST_SEND_CR   | sending carriage return
// ST_SEND_LF   | sending line feed, then back to idle
module freq_report_uart #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int BAUD    = 115200,
    parameter int COUNT_W = 40
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [COUNT_W-1:0] count_in,
    input  logic               count_valid,
    output logic               uart_tx,
    output logic               busy,
    output logic               overrun
);

    import freq_pkg::*;

    localparam int DIV      = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int SHIFT_CW = $clog2(COUNT_W);

    rpt_state_t          state;
    logic [COUNT_W-1:0]  cnt_sr;
    logic [BCD_W-1:0]    bcd;
    logic [SHIFT_CW-1:0] shift_cnt;
    logic [3:0]          dig_idx;
    logic                tx_start;
    logic [7:0]          tx_data;
    logic                tx_busy;
    logic                tx_done;
    logic [3:0]          cur_digit;
    logic [3:0]          next_digit;

    assign cur_digit  = bcd_digit(bcd, dig_idx);
    assign next_digit = bcd_digit(bcd, dig_idx - 4'd1);

    // The next byte is requested in the same cycle the previous done is seen,
    // keeping the inter-byte gap at two idle cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt_sr    <= '0;
            bcd       <= '0;
            shift_cnt <= '0;
            dig_idx   <= '0;
            tx_start  <= 1'b0;
            tx_data   <= '0;
            busy      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            overrun  <= count_valid && (state != ST_IDLE);
            case (state)
                ST_IDLE: begin
                    if (count_valid) begin
                        cnt_sr    <= count_in;
                        bcd       <= '0;
                        shift_cnt <= SHIFT_CW'(COUNT_W - 1);
                        busy      <= 1'b1;
                        state     <= ST_CONVERT;
                    end
                end
                ST_CONVERT: begin
                    bcd    <= bcd_step(bcd, cnt_sr[COUNT_W-1]);
                    cnt_sr <= {cnt_sr[COUNT_W-2:0], 1'b0};
                    if (shift_cnt == '0) begin
                        dig_idx <= 4'(BCD_DIGITS - 1);
                        state   <= ST_SKIPZ;
                    end else begin
                        shift_cnt <= shift_cnt - 1'b1;
                    end
                end
                ST_SKIPZ: begin
                    if ((cur_digit != 4'd0) || (dig_idx == 4'd0)) begin
                        if (!tx_busy) begin
                            tx_start <= 1'b1;
                            tx_data  <= ASCII_ZERO + {4'd0, cur_digit};
                            state    <= ST_SEND_DIG;
                        end
                    end else begin
                        dig_idx <= dig_idx - 4'd1;
                    end
                end
                ST_SEND_DIG: begin
                    if (tx_done) begin
                        tx_start <= 1'b1;
                        if (dig_idx == 4'd0) begin
                            tx_data <= ASCII_CR;
                            state   <= ST_SEND_CR;
                        end else begin
                            tx_data <= ASCII_ZERO + {4'd0, next_digit};
                            dig_idx <= dig_idx - 4'd1;
                        end
                    end
                end
                ST_SEND_CR: begin
                    if (tx_done) begin
                        tx_start <= 1'b1;
                        tx_data  <= ASCII_LF;
                        state    <= ST_SEND_LF;
                    end
                end
                ST_SEND_LF: begin
                    if (tx_done) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    uart_tx_byte #(
        .DIV(DIV)
    ) u_tx (
        .clk  (clk),
        .rst  (rst),
        .start(tx_start),
        .data (tx_data),
        .tx   (uart_tx),
        .busy (tx_busy),
        .done (tx_done)
    );

endmodule

// File: tb/tb_freq_report_uart.sv
`timescale 1ns/1ps
module tb_freq_report_uart;

    // Fast instance: (5_000_000 + 57_600) / 115_200 = 43 cycles per bit.
    localparam int DIV_FAST = 43;
    localparam int DIV_DEF  = 434;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst, count_valid, uart_tx, busy, overrun;
    logic [39:0] count_in;
    logic        rst_def, count_valid_def, uart_tx_def, busy_def, overrun_def;
    logic [39:0] count_in_def;

    freq_report_uart #(.CLK_HZ(5_000_000), .BAUD(115_200), .COUNT_W(40)) dut (
        .clk(clk), .rst(rst), .count_in(count_in), .count_valid(count_valid),
        .uart_tx(uart_tx), .busy(busy), .overrun(overrun)
    );

    freq_report_uart dut_def (
        .clk(clk), .rst(rst_def), .count_in(count_in_def), .count_valid(count_valid_def),
        .uart_tx(uart_tx_def), .busy(busy_def), .overrun(overrun_def)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] exp_q[$];
    bit         abort_frame   = 1'b0;
    int         bytes_started = 0;
    int         last_stop_cyc = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endfunction

    function automatic void check_range(input string name, input int act, input int lo, input int hi);
        n_tests++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endfunction

    // Called at the negedge where the start bit is first seen; checks every
    // cycle of the 10-bit frame against the expected waveform.
    task automatic check_byte(input bit use_def, input logic [7:0] exp, input int div,
                              input string name, output bit aborted);
        logic [9:0] fb;
        logic [7:0] got;
        logic       ln;
        int         bad;
        fb = {1'b1, exp, 1'b0};
        got = '0;
        bad = 0;
        aborted = 1'b0;
        for (int off = 0; off < 10 * div; off++) begin
            if (off > 0) @(negedge clk);
            if (!use_def && abort_frame) begin
                aborted = 1'b1;
                break;
            end
            ln = use_def ? uart_tx_def : uart_tx;
            if (ln !== fb[off / div]) bad++;
            if ((off % div) == div / 2 && (off / div) >= 1 && (off / div) <= 8)
                got[(off / div) - 1] = ln;
        end
        if (!aborted) begin
            n_tests++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL %s: byte got %02h with %0d wrong line cycles, expected %02h",
                         name, got, bad, exp);
            end
        end
    endtask

    // Monitor for the fast instance: pops one expected byte per start bit.
    initial begin : monitor
        bit         have_start;
        bit         ab;
        logic [7:0] e;
        have_start = 1'b0;
        forever begin
            if (!have_start) begin
                @(negedge clk);
                have_start = !abort_frame && (uart_tx === 1'b0);
            end else begin
                have_start = 1'b0;
                bytes_started++;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_byte: start bit at cycle %0d, expected none", cyc);
                    repeat (10 * DIV_FAST - 1) @(negedge clk);
                end else begin
                    e = exp_q.pop_front();
                    check_byte(1'b0, e, DIV_FAST, "fast_byte", ab);
                    if (!ab) begin
                        last_stop_cyc = cyc;
                        if (e != 8'h0A && exp_q.size() > 0) begin
                            for (int g = 1; g <= 3; g++) begin
                                @(negedge clk);
                                if (uart_tx === 1'b0) begin
                                    have_start = 1'b1;
                                    break;
                                end
                            end
                            check("byte_gap", have_start, 1'b1);
                        end
                    end
                end
            end
        end
    end

    task automatic push_frame(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    task automatic issue(input logic [39:0] v, output int acc);
        acc = cyc;
        count_in = v;
        count_valid = 1'b1;
        @(negedge clk);
        count_valid = 1'b0;
    endtask

    task automatic first_start(input int acc, input string name);
        int n;
        n = 0;
        while (uart_tx !== 1'b0 && n < 80) begin
            @(negedge clk);
            n++;
        end
        check_range(name, cyc - acc - 1, 41, 56);
    endtask

    task automatic wait_idle(input string name, output int fall);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 20 * 10 * DIV_FAST) begin
            @(negedge clk);
            n++;
        end
        check({name, "_idle"}, busy, 1'b0);
        fall = cyc;
    endtask

    task automatic fast_seq();
        int acc, fall, b0, n;
        rst = 1'b1; count_valid = 1'b0; count_in = '0;
        repeat (3) @(negedge clk);
        check("rst_uart_tx", uart_tx, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // zero: "0\r\n"
        push_frame("0");
        issue(40'd0, acc);
        check("t1_busy_rise", busy, 1'b1);
        first_start(acc, "t1_latency");
        wait_idle("t1", fall);
        check("t1_busy_fall", fall, last_stop_cyc + 2);
        check("t1_drained", exp_q.size(), 0);
        repeat (20) @(negedge clk);

        // 1234567, then all-ones issued in the very cycle busy falls
        push_frame("1234567");
        issue(40'd1234567, acc);
        first_start(acc, "t2_latency");
        wait_idle("t2", fall);
        check("t2_busy_fall", fall, last_stop_cyc + 2);
        check("t2_drained", exp_q.size(), 0);
        push_frame("1099511627775");
        issue(40'hFF_FFFF_FFFF, acc);
        check("t3_accept_busy", busy, 1'b1);
        check("t3_no_overrun", overrun, 1'b0);
        first_start(acc, "t3_latency");
        wait_idle("t3", fall);
        check("t3_drained", exp_q.size(), 0);
        repeat (20) @(negedge clk);

        // second pulse 100 cycles into a frame
        push_frame("1234567");
        issue(40'd1234567, acc);
        repeat (99) @(negedge clk);
        count_in = 40'd999;
        count_valid = 1'b1;
        @(negedge clk);
        count_valid = 1'b0;
        check("t4_overrun_pulse", overrun, 1'b1);
        @(negedge clk);
        check("t4_overrun_clear", overrun, 1'b0);
        check("t4_busy_kept", busy, 1'b1);
        wait_idle("t4", fall);
        check("t4_drained", exp_q.size(), 0);
        repeat (20) @(negedge clk);

        // reset during the data bits of byte 2
        exp_q.push_back("1");
        exp_q.push_back("2");
        b0 = bytes_started;
        issue(40'd1234567, acc);
        n = 0;
        while (bytes_started < b0 + 2 && n < 4 * 10 * DIV_FAST) begin
            @(negedge clk);
            n++;
        end
        check("t5_byte2_started", bytes_started, b0 + 2);
        repeat (3 * DIV_FAST) @(negedge clk);
        abort_frame = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        check("t5_rst_tx", uart_tx, 1'b1);
        check("t5_rst_busy", busy, 1'b0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("t5_drained", exp_q.size(), 0);
        abort_frame = 1'b0;
        repeat (2 * DIV_FAST) @(negedge clk);
        check("t5_line_idle", uart_tx, 1'b1);

        push_frame("42");
        issue(40'd42, acc);
        first_start(acc, "t6_latency");
        wait_idle("t6", fall);
        check("t6_busy_fall", fall, last_stop_cyc + 2);
        check("t6_drained", exp_q.size(), 0);
    endtask

    // Default-parameter instance: one "0\r\n" frame at 434 cycles per bit.
    task automatic def_seq();
        logic [7:0] exp_def [3];
        int         acc, n, last_stop;
        bit         ab;
        exp_def = '{8'h30, 8'h0D, 8'h0A};
        rst_def = 1'b1; count_valid_def = 1'b0; count_in_def = '0;
        repeat (3) @(negedge clk);
        rst_def = 1'b0;
        @(negedge clk);
        acc = cyc;
        count_valid_def = 1'b1;
        @(negedge clk);
        count_valid_def = 1'b0;
        last_stop = 0;
        for (int b = 0; b < 3; b++) begin
            n = 0;
            while (uart_tx_def !== 1'b0 && n < 80) begin
                @(negedge clk);
                n++;
            end
            if (b == 0) check_range("def_latency", cyc - acc - 1, 41, 56);
            else check_range("def_gap", n, 1, 3);
            if (uart_tx_def !== 1'b0) break;
            check_byte(1'b1, exp_def[b], DIV_DEF, "def_byte", ab);
            last_stop = cyc;
        end
        n = 0;
        while (busy_def !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("def_busy_fall", cyc, last_stop + 2);
        check("def_overrun", overrun_def, 1'b0);
    endtask

    initial begin
        rst = 1'b1; count_valid = 1'b0; count_in = '0;
        rst_def = 1'b1; count_valid_def = 1'b0; count_in_def = '0;
        fork
            fast_seq();
            def_seq();
        join
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #(10 * 80_000);
        $display("FAIL watchdog: simulation still running at cycle %0d, expected finish", cyc);
        $fatal(1);
    end

endmodule
